// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control/datapath bundle of the multi-cycle RV32I controller
// master = controller side, slave = datapath/memory side.
interface multicycle_control_fsm_if;
  logic [31:0] instr;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUctrl;
  logic [2:0]  ImmSrc;
  logic        instr_done;
  logic        err;

  modport master (
    input  instr, Zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, err
  );

  modport slave (
    output instr, Zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, instr_done, err
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore sequencing controller for the multi-cycle RV32I core
// Handshake-qualified enables (IRWrite/PCWrite/instr_done) follow mem_ready and Zero in the same cycle.
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR_PC, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [15:0] WAIT_LAST = (WAIT_LIMIT > 0) ? 16'(WAIT_LIMIT - 1) : 16'd0;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_mem_state;
  logic        w_waiting;
  logic        w_timeout;
  logic        w_r_legal;
  logic [2:0]  w_r_aluctrl;
  logic        w_unused;

  assign w_opcode    = bus.instr[6:0];
  assign w_funct3    = bus.instr[14:12];
  assign w_unused    = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_waiting   = w_mem_state && !bus.mem_ready;
  // Timeout fires on the WAIT_LIMIT-th consecutive waiting cycle, which by construction has mem_ready=0.
  assign w_timeout   = (WAIT_LIMIT > 0) && w_waiting && (r_wait == WAIT_LAST);

  always_comb begin
    w_r_legal   = 1'b1;
    w_r_aluctrl = 3'b000;
    case (w_funct3)
      3'b000:  w_r_aluctrl = bus.instr[30] ? 3'b001 : 3'b000;
      3'b100:  w_r_aluctrl = 3'b010;
      3'b111:  w_r_aluctrl = 3'b011;
      default: w_r_legal   = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = (w_funct3 == 3'b000) ? S_EXEC_I : S_ERROR;
          OP_B:              w_next = (w_funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR_ADR;
          default:           w_next = S_ERROR;
        endcase
      end
      S_MEMADR:   w_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready)  w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_EXEC_R:   w_next = w_r_legal ? S_ALUWB : S_ERROR;
      S_EXEC_I:   w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR_ADR: w_next = S_JALR_PC;
      S_JALR_PC:  w_next = S_ALUWB;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_ERROR;
    endcase
  end

  // Any state change clears the wait count, so each memory state starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait <= '0;
      else if (w_waiting)    r_wait <= r_wait + 16'd1;
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUctrl    = 3'b000;
    bus.ImmSrc     = 3'b000;
    bus.instr_done = 1'b0;
    bus.err        = 1'b0;
    // The reset state is FETCH, so outputs are gated to keep mem_req low while rst_n is held.
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.PCWrite   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
          bus.ImmSrc  = (w_opcode == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ImmSrc  = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          bus.ResultSrc  = 2'b01;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req    = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.AdrSrc     = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        S_EXEC_R: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUctrl = w_r_aluctrl;
        end
        S_EXEC_I: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        S_ALUWB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUctrl    = w_funct3[0] ? 3'b101 : 3'b111;
          bus.PCWrite    = bus.Zero;
          bus.instr_done = 1'b1;
        end
        S_JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        S_JALR_ADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        S_JALR_PC: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        S_ERROR: bus.err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed bench for multicycle_control_fsm
// Outputs are packed into one control word per cycle and compared against hand-built tables.
module tb_multicycle_control_fsm;

  logic clk;
  logic rst_n;
  logic rst_nb;
  int   n_checks;
  int   n_fail;

  multicycle_control_fsm_if ia ();
  multicycle_control_fsm_if ib ();

  multicycle_control_fsm #(.WAIT_LIMIT(0)) dut_a (.clk(clk), .rst_n(rst_n),  .bus(ia));
  multicycle_control_fsm #(.WAIT_LIMIT(4)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs [16];
  logic [19:0] exp_w [16];
  logic        rdy [16];
  logic        zr  [16];

  logic [19:0] W_IDLE, W_FETCH_WAIT, W_FETCH_RDY, W_DECODE, W_DECODE_J, W_MEMADR_L, W_MEMADR_S;
  logic [19:0] W_MEMREAD, W_MEMWB, W_MEMWRITE, W_MEMWRITE_RDY, W_EXEC_I, W_ALUWB;
  logic [19:0] W_EXEC_SUB, W_EXEC_XOR, W_EXEC_BAD, W_BEQ_TAKEN, W_BNE_NOT;
  logic [19:0] W_JAL, W_JALR_ADR, W_JALR_PC, W_ERROR;

  function automatic logic [19:0] cw(input logic mreq, mw, adr, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] ac, imm,
                                     input logic done, er);
    return {mreq, mw, adr, irw, pcw, rw, rs, sa, sb, ac, imm, done, er};
  endfunction

  function automatic logic [19:0] ctl_a();
    return {ia.mem_req, ia.MemWrite, ia.AdrSrc, ia.IRWrite, ia.PCWrite, ia.RegWrite,
            ia.ResultSrc, ia.ALUSrcA, ia.ALUSrcB, ia.ALUctrl, ia.ImmSrc, ia.instr_done, ia.err};
  endfunction

  function automatic logic [19:0] ctl_b();
    return {ib.mem_req, ib.MemWrite, ib.AdrSrc, ib.IRWrite, ib.PCWrite, ib.RegWrite,
            ib.ResultSrc, ib.ALUSrcA, ib.ALUSrcB, ib.ALUctrl, ib.ImmSrc, ib.instr_done, ib.err};
  endfunction

  task automatic capture_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ia.mem_ready = rdy[i];
      ia.Zero      = zr[i];
      #2;
      obs[i] = ctl_a();
    end
  endtask

  task automatic capture_b(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ib.mem_ready = rdy[i];
      ib.Zero      = zr[i];
      #2;
      obs[i] = ctl_b();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if (ctl_a() !== W_IDLE) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", ctl_a(), W_IDLE);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl_a() !== W_FETCH_WAIT) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", ctl_a(), W_FETCH_WAIT);
    end
    ia.instr = 32'h0000A183;
    rdy[0] = 1; rdy[1] = 1; rdy[2] = 1; rdy[3] = 0;
    for (int i = 0; i < 4; i++) zr[i] = 0;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_MEMADR_L; exp_w[3] = W_MEMREAD;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL reset_lw_prefix cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ia.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_mem_req: got %b expected 0", ia.mem_req);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #3;
      n_checks++;
      if (ctl_a() !== W_IDLE) begin
        n_fail++;
        $display("FAIL reset_mid_memread cycle %0d: got %h expected %h", i, ctl_a(), W_IDLE);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ctl_a() !== W_FETCH_WAIT) begin
      n_fail++;
      $display("FAIL reset_refetch: got %h expected %h", ctl_a(), W_FETCH_WAIT);
    end
  endtask

  task automatic test_addi();
    ia.instr = 32'h00500093;
    for (int i = 0; i < 5; i++) begin rdy[i] = 1; zr[i] = 0; end
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_EXEC_I; exp_w[3] = W_ALUWB;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL addi cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_r_type();
    for (int i = 0; i < 8; i++) begin rdy[i] = 1; zr[i] = 0; end
    ia.instr = 32'h40208133;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_EXEC_SUB; exp_w[3] = W_ALUWB;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL sub cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
    ia.instr = 32'h0020C1B3;
    exp_w[2] = W_EXEC_XOR;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL xor cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_branch();
    ia.instr = 32'h00208463;
    for (int i = 0; i < 3; i++) begin rdy[i] = 1; zr[i] = 1; end
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_BEQ_TAKEN;
    capture_a(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL beq cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
    ia.instr = 32'h00209463;
    for (int i = 0; i < 3; i++) zr[i] = 0;
    exp_w[2] = W_BNE_NOT;
    capture_a(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL bne cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    ia.instr = 32'h0000A183;
    for (int i = 0; i < 10; i++) begin rdy[i] = 1; zr[i] = 0; end
    rdy[0] = 0; rdy[1] = 0; rdy[2] = 0; rdy[6] = 0; rdy[7] = 0;
    exp_w[0] = W_FETCH_WAIT; exp_w[1] = W_FETCH_WAIT; exp_w[2] = W_FETCH_WAIT;
    exp_w[3] = W_FETCH_RDY;  exp_w[4] = W_DECODE;     exp_w[5] = W_MEMADR_L;
    exp_w[6] = W_MEMREAD;    exp_w[7] = W_MEMREAD;    exp_w[8] = W_MEMREAD;
    exp_w[9] = W_MEMWB;
    capture_a(10);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
    ia.instr = 32'h0020A223;
    for (int i = 0; i < 4; i++) rdy[i] = 1;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_MEMADR_S; exp_w[3] = W_MEMWRITE_RDY;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin rdy[i] = 1; zr[i] = 0; end
    ia.instr = 32'h008000EF;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE_J; exp_w[2] = W_JAL; exp_w[3] = W_ALUWB;
    capture_a(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL jal cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
    ia.instr = 32'h000100E7;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE;  exp_w[2] = W_JALR_ADR;
    exp_w[3] = W_JALR_PC;   exp_w[4] = W_ALUWB;
    capture_a(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL jalr cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_illegal();
    ia.instr = 32'h00209133;
    for (int i = 0; i < 6; i++) begin rdy[i] = 1; zr[i] = 0; end
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE; exp_w[2] = W_EXEC_BAD;
    exp_w[3] = W_ERROR;     exp_w[4] = W_ERROR;  exp_w[5] = W_ERROR;
    capture_a(6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL illegal_rtype cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_timeout();
    ib.instr = 32'h0020A223;
    @(posedge clk);
    #2;
    rst_nb = 1'b1;
    for (int i = 0; i < 9; i++) begin rdy[i] = 0; zr[i] = 0; end
    rdy[0] = 1;
    exp_w[0] = W_FETCH_RDY; exp_w[1] = W_DECODE;   exp_w[2] = W_MEMADR_S;
    exp_w[3] = W_MEMWRITE;  exp_w[4] = W_MEMWRITE; exp_w[5] = W_MEMWRITE;
    exp_w[6] = W_MEMWRITE;  exp_w[7] = W_ERROR;    exp_w[8] = W_ERROR;
    capture_b(9);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL sw_timeout cycle %0d: got %h expected %h", i, obs[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    rst_nb = 1'b0;
    ia.instr = 32'h0; ia.Zero = 1'b0; ia.mem_ready = 1'b0;
    ib.instr = 32'h0; ib.Zero = 1'b0; ib.mem_ready = 1'b0;

    W_IDLE         = 20'h0;
    W_FETCH_WAIT   = cw(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
    W_FETCH_RDY    = cw(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
    W_DECODE       = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0, 0);
    W_DECODE_J     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0, 0);
    W_MEMADR_L     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    W_MEMADR_S     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0);
    W_MEMREAD      = cw(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
    W_MEMWB        = cw(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    W_MEMWRITE     = cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
    W_MEMWRITE_RDY = cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    W_EXEC_I       = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    W_ALUWB        = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
    W_EXEC_SUB     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0);
    W_EXEC_XOR     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0, 0);
    W_EXEC_BAD     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0, 0);
    W_BEQ_TAKEN    = cw(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 3'b111, 3'b000, 1, 0);
    W_BNE_NOT      = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 1, 0);
    W_JAL          = cw(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0);
    W_JALR_ADR     = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0);
    W_JALR_PC      = cw(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0);
    W_ERROR        = cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1);

    test_reset();
    test_addi();
    test_r_type();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
